yuv422_word_packer: RTL and testbench

// - Downstream of the colour-transform stage in RGB->YUV mode: consumes its 8-bit yuv_out stream
//   (ordered U0, Y0, V0, Y1 per pixel pair) qualified by out_valid.
// - Packs each 4-byte group into a 32-bit 4:2:2 macropixel word {U,Y0,V,Y1}.
// - Buffers words in a small FIFO and presents them on a valid/ready interface to the frame writer.

---
 rtl/cte_pkg.sv | 20 ++
 rtl/yuv422_word_packer_if.sv | 29 ++
 rtl/cte_sync_fifo.sv | 54 +++++
 rtl/yuv422_word_packer.sv | 108 ++++++++++
 tb/tb_yuv422_word_packer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cte_pkg.sv
// Shared definitions for the colour-transform output path.
//   BW       : width of one transform-stage byte
//   WORD_BW  : width of one packed 4:2:2 macropixel word
//   phase_e  : byte position within a U,Y0,V,Y1 group
//   sat_inc8 : 8-bit increment that holds at 8'hFF
package cte_pkg;
  localparam int BW      = 8;
  localparam int WORD_BW = 32;

  typedef enum logic [1:0] {
    PH_U  = 2'd0,
    PH_Y0 = 2'd1,
    PH_V  = 2'd2,
    PH_Y1 = 2'd3
  } phase_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/yuv422_word_packer_if.sv
// Byte-in / word-out bundle of the 4:2:2 word packer.
//   in_valid, in_byte, phase_clr : byte stream from the transform stage
//   word_valid, word_ready, word_data : packed-word handshake to the frame writer
//   level, overflow, drop_cnt    : FIFO status
// slave = packer side, master = stimulus/consumer side.
interface yuv422_word_packer_if #(parameter int DEPTH = 8);
  import cte_pkg::*;
  localparam int AW = $clog2(DEPTH);

  logic               in_valid;
  logic [BW-1:0]      in_byte;
  logic               phase_clr;
  logic               word_valid;
  logic               word_ready;
  logic [WORD_BW-1:0] word_data;
  logic [AW:0]        level;
  logic               overflow;
  logic [7:0]         drop_cnt;

  modport slave (
    input  in_valid, in_byte, phase_clr, word_ready,
    output word_valid, word_data, level, overflow, drop_cnt
  );

  modport master (
    output in_valid, in_byte, phase_clr, word_ready,
    input  word_valid, word_data, level, overflow, drop_cnt
  );
endinterface

// File: rtl/cte_sync_fifo.sv
// Single-clock FIFO with AW+1 bit wrapping pointers.
//   clk, reset : clock, asynchronous active-high reset of pointers
//   i_push/i_data : write request; accepted when not full or when a pop
//                   happens on the same edge
//   i_pop      : read request; ignored when empty
//   o_data     : head entry, combinational; zero when empty
//   o_full, o_empty, o_level : occupancy status
module cte_sync_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;

  // No bypass: a push into an empty FIFO is only visible the next cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is never read while the FIFO is empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/yuv422_word_packer.sv
// Packs the transform-stage byte stream (U0,Y0,V0,Y1) into 32-bit 4:2:2
// words {U,Y0,V,Y1} and buffers them for the frame writer.
//   clk, reset : clock, asynchronous active-high reset of all state
//   bus        : yuv422_word_packer_if.slave (byte input, word handshake,
//                level / overflow / drop_cnt status)
// Optional feature: define YUV422_PACK_DROP_CNT_EN to build a saturating
// dropped-word counter on drop_cnt; otherwise drop_cnt is tied to zero.
module yuv422_word_packer
  import cte_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  yuv422_word_packer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  phase_e             r_phase, w_phase_nxt;
  logic [BW-1:0]      r_slot0, r_slot1, r_slot2;
  logic [BW-1:0]      w_slot0_nxt, w_slot1_nxt, w_slot2_nxt;
  logic               w_push;
  logic [WORD_BW-1:0] w_word;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  logic [AW:0]        w_level;
  logic               r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= PH_U;
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_slot2 <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
      r_slot2 <= w_slot2_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    w_slot2_nxt = r_slot2;
    w_push      = 1'b0;
    w_word      = {r_slot0, r_slot1, r_slot2, bus.in_byte};
    if (bus.phase_clr) begin
      // Re-align: discard the partial group; a coincident byte starts a new one.
      w_phase_nxt = PH_U;
      w_slot0_nxt = '0;
      w_slot1_nxt = '0;
      w_slot2_nxt = '0;
      if (bus.in_valid) begin
        w_slot0_nxt = bus.in_byte;
        w_phase_nxt = PH_Y0;
      end
    end else if (bus.in_valid) begin
      case (r_phase)
        PH_U:    begin w_slot0_nxt = bus.in_byte; w_phase_nxt = PH_Y0; end
        PH_Y0:   begin w_slot1_nxt = bus.in_byte; w_phase_nxt = PH_V;  end
        PH_V:    begin w_slot2_nxt = bus.in_byte; w_phase_nxt = PH_Y1; end
        default: begin w_push      = 1'b1;        w_phase_nxt = PH_U;  end
      endcase
    end
  end

  cte_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_BW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (bus.word_ready),
    .o_data  (bus.word_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // A full FIFO is never empty, so word_ready alone means a pop frees a slot.
  assign w_drop = w_push & w_full & ~bus.word_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef YUV422_PACK_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= sat_inc8(r_drop_cnt);
  end
  assign bus.drop_cnt = r_drop_cnt;
`else
  assign bus.drop_cnt = 8'h00;
`endif

  assign bus.word_valid = ~w_empty;
  assign bus.level      = w_level;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_yuv422_word_packer.sv
module tb_yuv422_word_packer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  yuv422_word_packer_if #(.DEPTH(DEPTH)) bus ();

  yuv422_word_packer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard and reference state
  logic [31:0] q[$];
  int          m_phase;
  logic [7:0]  m_s [3];
  int          m_lvl;
  logic        m_ovf;
  logic [7:0]  m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_phase = 0;
    m_s[0] = 0; m_s[1] = 0; m_s[2] = 0;
    m_lvl = 0;
    m_ovf = 0;
    m_drop = 0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level"}, 32'(bus.level), 32'(m_lvl));
    chk({tag, "_valid"}, 32'(bus.word_valid), 32'(m_lvl > 0));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, "_drop"}, 32'(bus.drop_cnt), 32'(m_drop));
    chk({tag, "_head"}, bus.word_data, (m_lvl > 0) ? q[0] : 32'h0);
  endtask

  // One clock: drive, check head if popping, update reference, check status.
  task automatic step(input logic v, input logic [7:0] b, input logic clr, input logic rdy);
    logic        do_pop;
    logic        done;
    logic [31:0] w;
    bus.in_valid   = v;
    bus.in_byte    = b;
    bus.phase_clr  = clr;
    bus.word_ready = rdy;
    #1;
    do_pop = rdy && (m_lvl > 0);
    if (do_pop) chk("pop_data", bus.word_data, q[0]);
    done = 1'b0;
    w = 32'h0;
    if (clr) begin
      m_phase = 0;
      m_s[0] = 0; m_s[1] = 0; m_s[2] = 0;
      if (v) begin m_s[0] = b; m_phase = 1; end
    end else if (v) begin
      if (m_phase < 3) begin
        m_s[m_phase] = b;
        m_phase++;
      end else begin
        w = {m_s[0], m_s[1], m_s[2], b};
        done = 1'b1;
        m_phase = 0;
      end
    end
    if (done) begin
      if (m_lvl < DEPTH || do_pop) begin
        q.push_back(w);
        m_lvl++;
      end else begin
        m_ovf = 1'b1;
`ifdef YUV422_PACK_DROP_CNT_EN
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
`endif
      end
    end
    if (do_pop) begin
      void'(q.pop_front());
      m_lvl--;
    end
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.phase_clr  = 1'b0;
    bus.word_ready = 1'b0;
    check_status("step");
  endtask

  task automatic send_group(input logic [31:0] wd, input int gap);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, wd[31-8*i -: 8], 1'b0, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_rst_level"}, 32'(bus.level), 32'h0);
    chk({tag, "_rst_valid"}, 32'(bus.word_valid), 32'h0);
    chk({tag, "_rst_data"}, bus.word_data, 32'h0);
    chk({tag, "_rst_ovf"}, 32'(bus.overflow), 32'h0);
    chk({tag, "_rst_drop"}, 32'(bus.drop_cnt), 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_byte    = 8'h00;
    bus.phase_clr  = 1'b0;
    bus.word_ready = 1'b0;
    model_clear();

    // Power-on reset
    apply_reset("init");
    check_status("after_reset");

    // Single group, then pop
    send_group(32'h0A141E28, 0);
    chk("first_word", bus.word_data, 32'h0A141E28);
    chk("first_level", 32'(bus.level), 32'd1);
    drain(1);
    chk("after_pop_valid", 32'(bus.word_valid), 32'h0);
    chk("after_pop_data", bus.word_data, 32'h0);

    // Fill to DEPTH, then a 9th group is dropped
    for (int g = 1; g <= 8; g++)
      send_group({4'(g), 4'h0, 4'(g), 4'h1, 4'(g), 4'h2, 4'(g), 4'h3}, 0);
    chk("full_level", 32'(bus.level), 32'd8);
    send_group(32'h90919293, 0);
    chk("drop_ovf", 32'(bus.overflow), 32'h1);
    chk("drop_level", 32'(bus.level), 32'd8);
`ifdef YUV422_PACK_DROP_CNT_EN
    chk("drop_cnt", 32'(bus.drop_cnt), 32'd1);
`else
    chk("drop_cnt", 32'(bus.drop_cnt), 32'd0);
`endif
    chk("first_kept", bus.word_data, 32'h10111213);
    drain(8);
    chk("ovf_sticky", 32'(bus.overflow), 32'h1);

    // Full FIFO, Y1 of the 9th group coincides with a pop
    for (int g = 1; g <= 8; g++)
      send_group({4'(g), 4'h4, 4'(g), 4'h5, 4'(g), 4'h6, 4'(g), 4'h7}, 0);
    step(1'b1, 8'h90, 1'b0, 1'b0);
    step(1'b1, 8'h91, 1'b0, 1'b0);
    step(1'b1, 8'h92, 1'b0, 1'b0);
    step(1'b1, 8'h93, 1'b0, 1'b1);
    chk("coinc_level", 32'(bus.level), 32'd8);
`ifdef YUV422_PACK_DROP_CNT_EN
    chk("coinc_drop", 32'(bus.drop_cnt), 32'd1);
`else
    chk("coinc_drop", 32'(bus.drop_cnt), 32'd0);
`endif
    drain(7);
    chk("coinc_last", bus.word_data, 32'h90919293);
    drain(1);

    // phase_clr re-alignment with a coincident byte
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b0);
    chk("clr_word", bus.word_data, 32'h01020304);
    drain(1);

    // Reset mid-group with three words buffered
    send_group(32'hA1A2A3A4, 0);
    send_group(32'hB1B2B3B4, 0);
    send_group(32'hC1C2C3C4, 0);
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b0, 1'b0);
    apply_reset("mid");
    send_group(32'h11223344, 0);
    chk("post_reset_word", bus.word_data, 32'h11223344);
    chk("post_reset_level", 32'(bus.level), 32'd1);
    drain(1);

    // Gapped versus back-to-back bytes
    send_group(32'h5A6B7C8D, 0);
    send_group(32'h5A6B7C8D, 2);
    chk("gap_level", 32'(bus.level), 32'd2);
    chk("gap_first", bus.word_data, 32'h5A6B7C8D);
    drain(1);
    chk("gap_second", bus.word_data, 32'h5A6B7C8D);
    drain(1);
    check_status("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
